// File: rtl/rv32_decode_stage.sv
// RV32I+M decode stage: registers one fetched word per handshake and emits it
// classified by mnemonic, format and category with register fields and immediate.

package riscv_instruction_properties;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        NOP, FENCE, FENCEI, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        INVALID_INSTR
    } riscv_instr_name_t;

    typedef enum logic [2:0] {
        R_FORMAT, I_FORMAT, S_FORMAT, B_FORMAT, U_FORMAT, J_FORMAT
    } riscv_instr_format_t;

    typedef enum logic [3:0] {
        LOAD, STORE, SHIFT, ARITHMETIC, LOGICAL, COMPARE,
        BRANCH, JUMP, SYNCH, SYSTEM, CSR, TRAP
    } riscv_instr_cateogry_t;

    typedef enum logic [4:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2,
        S0, S1, A0, A1, A2, A3, A4, A5,
        A6, A7, S2, S3, S4, S5, S6, S7,
        S8, S9, S10, S11, T3, T4, T5, T6
    } riscv_reg_t;

endpackage

module rv32_decode_stage
    import riscv_instruction_properties::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [31:0]           in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_instr,
    output riscv_instr_name_t     out_name,
    output riscv_instr_format_t   out_format,
    output riscv_instr_cateogry_t out_category,
    output riscv_reg_t            out_rd,
    output riscv_reg_t            out_rs1,
    output riscv_reg_t            out_rs2,
    output logic [31:0]           out_imm,
    output logic                  out_illegal,
    output logic [CNT_W-1:0]      decoded_cnt,
    output logic [CNT_W-1:0]      illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic [6:0]            funct7_s;
    riscv_instr_name_t     dec_name_s;
    riscv_instr_format_t   dec_fmt_s;
    riscv_instr_cateogry_t dec_cat_s;
    riscv_reg_t            dec_rd_s;
    riscv_reg_t            dec_rs1_s;
    riscv_reg_t            dec_rs2_s;
    logic [31:0]           dec_imm_s;
    logic                  dec_illegal_s;
    logic                  capture_s;
    logic                  drain_s;

    assign opcode_s  = in_instr[6:0];
    assign funct3_s  = in_instr[14:12];
    assign funct7_s  = in_instr[31:25];

    assign in_ready  = !flush && (!out_valid || out_ready);
    assign capture_s = in_valid && in_ready;
    assign drain_s   = out_valid && out_ready;

    function automatic riscv_instr_format_t fmt_of(input riscv_instr_name_t n);
        case (n)
            LUI, AUIPC:                         return U_FORMAT;
            JAL:                                return J_FORMAT;
            BEQ, BNE, BLT, BGE, BLTU, BGEU:     return B_FORMAT;
            SB, SH, SW:                         return S_FORMAT;
            ADD, SUB, SLL, SLT, SLTU, XOR,
            SRL, SRA, OR, AND,
            MUL, MULH, MULHSU, MULHU,
            DIV, DIVU, REM, REMU,
            INVALID_INSTR:                      return R_FORMAT;
            default:                            return I_FORMAT;
        endcase
    endfunction

    function automatic riscv_instr_cateogry_t cat_of(input riscv_instr_name_t n);
        case (n)
            LUI, AUIPC, ADD, SUB, ADDI, NOP,
            MUL, MULH, MULHSU, MULHU,
            DIV, DIVU, REM, REMU:               return ARITHMETIC;
            SLT, SLTU, SLTI, SLTIU:             return COMPARE;
            AND, OR, XOR, ANDI, ORI, XORI:      return LOGICAL;
            SLL, SRL, SRA, SLLI, SRLI, SRAI:    return SHIFT;
            JAL, JALR:                          return JUMP;
            BEQ, BNE, BLT, BGE, BLTU, BGEU:     return BRANCH;
            LB, LH, LW, LBU, LHU:               return LOAD;
            SB, SH, SW:                         return STORE;
            FENCE, FENCEI:                      return SYNCH;
            ECALL, EBREAK:                      return SYSTEM;
            CSRRW, CSRRS, CSRRC,
            CSRRWI, CSRRSI, CSRRCI:             return CSR;
            default:                            return TRAP;
        endcase
    endfunction

    // Mnemonic decode from opcode, funct3 and funct7
    always_comb begin
        dec_name_s = INVALID_INSTR;
        case (opcode_s)
            7'b0110111: dec_name_s = LUI;
            7'b0010111: dec_name_s = AUIPC;
            7'b1101111: dec_name_s = JAL;
            7'b1100111: dec_name_s = (funct3_s == 3'b000) ? JALR : INVALID_INSTR;
            7'b1100011: begin
                case (funct3_s)
                    3'b000:  dec_name_s = BEQ;
                    3'b001:  dec_name_s = BNE;
                    3'b100:  dec_name_s = BLT;
                    3'b101:  dec_name_s = BGE;
                    3'b110:  dec_name_s = BLTU;
                    3'b111:  dec_name_s = BGEU;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b0000011: begin
                case (funct3_s)
                    3'b000:  dec_name_s = LB;
                    3'b001:  dec_name_s = LH;
                    3'b010:  dec_name_s = LW;
                    3'b100:  dec_name_s = LBU;
                    3'b101:  dec_name_s = LHU;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b0100011: begin
                case (funct3_s)
                    3'b000:  dec_name_s = SB;
                    3'b001:  dec_name_s = SH;
                    3'b010:  dec_name_s = SW;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b0010011: begin
                case (funct3_s)
                    3'b000:  dec_name_s = (in_instr == 32'h0000_0013) ? NOP : ADDI;
                    3'b010:  dec_name_s = SLTI;
                    3'b011:  dec_name_s = SLTIU;
                    3'b100:  dec_name_s = XORI;
                    3'b110:  dec_name_s = ORI;
                    3'b111:  dec_name_s = ANDI;
                    3'b001:  dec_name_s = (funct7_s == 7'b0000000) ? SLLI : INVALID_INSTR;
                    3'b101:  dec_name_s = (funct7_s == 7'b0000000) ? SRLI :
                                          (funct7_s == 7'b0100000) ? SRAI : INVALID_INSTR;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b0110011: begin
                case (funct7_s)
                    7'b0000000: begin
                        case (funct3_s)
                            3'b000:  dec_name_s = ADD;
                            3'b001:  dec_name_s = SLL;
                            3'b010:  dec_name_s = SLT;
                            3'b011:  dec_name_s = SLTU;
                            3'b100:  dec_name_s = XOR;
                            3'b101:  dec_name_s = SRL;
                            3'b110:  dec_name_s = OR;
                            3'b111:  dec_name_s = AND;
                            default: dec_name_s = INVALID_INSTR;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3_s)
                            3'b000:  dec_name_s = SUB;
                            3'b101:  dec_name_s = SRA;
                            default: dec_name_s = INVALID_INSTR;
                        endcase
                    end
                    7'b0000001: begin
                        case (funct3_s)
                            3'b000:  dec_name_s = MUL;
                            3'b001:  dec_name_s = MULH;
                            3'b010:  dec_name_s = MULHSU;
                            3'b011:  dec_name_s = MULHU;
                            3'b100:  dec_name_s = DIV;
                            3'b101:  dec_name_s = DIVU;
                            3'b110:  dec_name_s = REM;
                            3'b111:  dec_name_s = REMU;
                            default: dec_name_s = INVALID_INSTR;
                        endcase
                    end
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b0001111: begin
                case (funct3_s)
                    3'b000:  dec_name_s = FENCE;
                    3'b001:  dec_name_s = FENCEI;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            7'b1110011: begin
                case (funct3_s)
                    // Only the two exact environment-call encodings are accepted
                    3'b000:  dec_name_s = (in_instr == 32'h0000_0073) ? ECALL :
                                          (in_instr == 32'h0010_0073) ? EBREAK : INVALID_INSTR;
                    3'b001:  dec_name_s = CSRRW;
                    3'b010:  dec_name_s = CSRRS;
                    3'b011:  dec_name_s = CSRRC;
                    3'b101:  dec_name_s = CSRRWI;
                    3'b110:  dec_name_s = CSRRSI;
                    3'b111:  dec_name_s = CSRRCI;
                    default: dec_name_s = INVALID_INSTR;
                endcase
            end
            default: dec_name_s = INVALID_INSTR;
        endcase
    end

    // Register fields and immediate, masked to what the format actually carries
    always_comb begin
        dec_fmt_s     = fmt_of(dec_name_s);
        dec_cat_s     = cat_of(dec_name_s);
        dec_illegal_s = (dec_name_s == INVALID_INSTR);
        dec_rd_s      = ZERO;
        dec_rs1_s     = ZERO;
        dec_rs2_s     = ZERO;
        dec_imm_s     = 32'h0000_0000;
        if (dec_illegal_s) begin
            dec_imm_s = 32'h0000_0000;
        end else begin
            case (dec_fmt_s)
                R_FORMAT: begin
                    dec_rd_s  = riscv_reg_t'(in_instr[11:7]);
                    dec_rs1_s = riscv_reg_t'(in_instr[19:15]);
                    dec_rs2_s = riscv_reg_t'(in_instr[24:20]);
                end
                I_FORMAT: begin
                    dec_rd_s  = riscv_reg_t'(in_instr[11:7]);
                    dec_rs1_s = riscv_reg_t'(in_instr[19:15]);
                    dec_imm_s = (dec_cat_s == CSR) ? {20'h00000, in_instr[31:20]}
                                                   : {{20{in_instr[31]}}, in_instr[31:20]};
                end
                S_FORMAT: begin
                    dec_rs1_s = riscv_reg_t'(in_instr[19:15]);
                    dec_rs2_s = riscv_reg_t'(in_instr[24:20]);
                    dec_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                B_FORMAT: begin
                    dec_rs1_s = riscv_reg_t'(in_instr[19:15]);
                    dec_rs2_s = riscv_reg_t'(in_instr[24:20]);
                    dec_imm_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
                end
                U_FORMAT: begin
                    dec_rd_s  = riscv_reg_t'(in_instr[11:7]);
                    dec_imm_s = {in_instr[31:12], 12'h000};
                end
                J_FORMAT: begin
                    dec_rd_s  = riscv_reg_t'(in_instr[11:7]);
                    dec_imm_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                end
                default: begin
                    dec_imm_s = 32'h0000_0000;
                end
            endcase
        end
    end

    // Output valid: flush wins, capture sets, a bare output handshake clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture_s) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Output payload register, loaded only on an input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc       <= 32'h0000_0000;
            out_instr    <= 32'h0000_0000;
            out_name     <= INVALID_INSTR;
            out_format   <= R_FORMAT;
            out_category <= TRAP;
            out_rd       <= ZERO;
            out_rs1      <= ZERO;
            out_rs2      <= ZERO;
            out_imm      <= 32'h0000_0000;
            out_illegal  <= 1'b0;
        end else if (capture_s) begin
            out_pc       <= in_pc;
            out_instr    <= in_instr;
            out_name     <= dec_name_s;
            out_format   <= dec_fmt_s;
            out_category <= dec_cat_s;
            out_rd       <= dec_rd_s;
            out_rs1      <= dec_rs1_s;
            out_rs2      <= dec_rs2_s;
            out_imm      <= dec_imm_s;
            out_illegal  <= dec_illegal_s;
        end
    end

    // Saturating statistics, counted on output handshakes even during flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_cnt <= {CNT_W{1'b0}};
            illegal_cnt <= {CNT_W{1'b0}};
        end else begin
            if (drain_s && (decoded_cnt != CNT_MAX)) begin
                decoded_cnt <= decoded_cnt + CNT_ONE;
            end
            if (drain_s && out_illegal && (illegal_cnt != CNT_MAX)) begin
                illegal_cnt <= illegal_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Scoreboard bench for rv32_decode_stage: hand-derived expected entries are queued
// at each input handshake and checked in order as output handshakes occur.

module tb_rv32_decode_stage;
    import riscv_instruction_properties::*;

    typedef struct {
        logic [31:0]           pc;
        logic [31:0]           instr;
        riscv_instr_name_t     name;
        riscv_instr_format_t   fmt;
        riscv_instr_cateogry_t cat;
        riscv_reg_t            rd;
        riscv_reg_t            rs1;
        riscv_reg_t            rs2;
        logic [31:0]           imm;
        logic                  ill;
    } exp_t;

    logic clk, rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_instr, out_imm;
    riscv_instr_name_t out_name;
    riscv_instr_format_t out_format;
    riscv_instr_cateogry_t out_category;
    riscv_reg_t out_rd, out_rs1, out_rs2;
    logic [15:0] decoded_cnt, illegal_cnt;

    logic s_in_ready, s_out_valid, s_out_illegal;
    logic [31:0] s_out_pc, s_out_instr, s_out_imm;
    riscv_instr_name_t s_out_name;
    riscv_instr_format_t s_out_format;
    riscv_instr_cateogry_t s_out_category;
    riscv_reg_t s_out_rd, s_out_rs1, s_out_rs2;
    logic [1:0] s_decoded_cnt, s_illegal_cnt;

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];
    exp_t mon_e;

    rv32_decode_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_name(out_name), .out_format(out_format),
        .out_category(out_category), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_illegal(out_illegal),
        .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    rv32_decode_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_instr(s_out_instr), .out_name(s_out_name),
        .out_format(s_out_format), .out_category(s_out_category), .out_rd(s_out_rd),
        .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_imm(s_out_imm),
        .out_illegal(s_out_illegal), .decoded_cnt(s_decoded_cnt), .illegal_cnt(s_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input riscv_instr_name_t name, input riscv_instr_format_t fmt,
                                input riscv_instr_cateogry_t cat, input riscv_reg_t rd,
                                input riscv_reg_t rs1, input riscv_reg_t rs2,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.name = name; e.fmt = fmt; e.cat = cat;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.ill = ill;
        return e;
    endfunction

    // Output-side scoreboard: pop and compare on every output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_output instr=%h got=extra_entry want=none", out_instr);
            end else begin
                mon_e = sb.pop_front();
                compared++;
                if ({out_pc, out_instr} !== {mon_e.pc, mon_e.instr}) begin
                    mismatched++;
                    $display("FAIL order pc/instr got=%h/%h want=%h/%h", out_pc, out_instr, mon_e.pc, mon_e.instr);
                end
                compared++;
                if ({out_name, out_format, out_category, out_illegal} !==
                    {mon_e.name, mon_e.fmt, mon_e.cat, mon_e.ill}) begin
                    mismatched++;
                    $display("FAIL class instr=%h got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/%b", mon_e.instr,
                             out_name, out_format, out_category, out_illegal,
                             mon_e.name, mon_e.fmt, mon_e.cat, mon_e.ill);
                end
                compared++;
                if ({out_rd, out_rs1, out_rs2, out_imm} !== {mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.imm}) begin
                    mismatched++;
                    $display("FAIL operands instr=%h got=%0d/%0d/%0d/%h want=%0d/%0d/%0d/%h", mon_e.instr,
                             out_rd, out_rs1, out_rs2, out_imm, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.imm);
                end
            end
        end
    end

    task automatic send(input exp_t e);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc = e.pc;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL send_timeout pc=%h got=no_handshake want=handshake", e.pc);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        #12;
        compared++;
        if ({out_valid, out_illegal, decoded_cnt, illegal_cnt} !== 34'h0) begin
            mismatched++;
            $display("FAIL reset_flags got=%b/%b/%0d/%0d want=0/0/0/0", out_valid, out_illegal, decoded_cnt, illegal_cnt);
        end
        compared++;
        if ({out_pc, out_instr, out_imm} !== 96'h0) begin
            mismatched++;
            $display("FAIL reset_data got=%h/%h/%h want=0/0/0", out_pc, out_instr, out_imm);
        end
        compared++;
        if ({out_name, out_format, out_category, out_rd, out_rs1, out_rs2} !==
            {INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO}) begin
            mismatched++;
            $display("FAIL reset_class got=%0d/%0d/%0d/%0d/%0d/%0d want=INVALID/R/TRAP/0/0/0",
                     out_name, out_format, out_category, out_rd, out_rs1, out_rs2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        send(mk(32'h100, 32'h0050_0093, ADDI, I_FORMAT, ARITHMETIC, RA, ZERO, ZERO, 32'h5, 1'b0));
        compared++;
        if ({out_valid, out_instr} !== {1'b1, 32'h0050_0093}) begin
            mismatched++;
            $display("FAIL addi_latency got=%b/%h want=1/00500093", out_valid, out_instr);
        end
        drain();
        compared++;
        if (decoded_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL addi_count got=%0d want=1", decoded_cnt);
        end
    endtask

    task automatic test_beq();
        out_ready = 1'b1;
        send(mk(32'h104, 32'hFE20_8EE3, BEQ, B_FORMAT, BRANCH, ZERO, RA, SP, 32'hFFFF_FFFC, 1'b0));
        drain();
        compared++;
        if ({decoded_cnt, illegal_cnt} !== {16'd2, 16'd0}) begin
            mismatched++;
            $display("FAIL beq_count got=%0d/%0d want=2/0", decoded_cnt, illegal_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(mk(32'h180, 32'h1234_52B7, LUI, U_FORMAT, ARITHMETIC, T0, ZERO, ZERO, 32'h1234_5000, 1'b0));
        rst_n = 1'b0;
        #2;
        compared++;
        if ({out_valid, decoded_cnt, illegal_cnt, out_instr, out_name} !== {33'h0, 32'h0, INVALID_INSTR}) begin
            mismatched++;
            $display("FAIL midreset got=%b/%0d/%0d/%h/%0d want=0/0/0/0/INVALID",
                     out_valid, decoded_cnt, illegal_cnt, out_instr, out_name);
        end
        sb.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if ({in_ready, out_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL midreset_release got=%b/%b want=1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal_nop();
        out_ready = 1'b1;
        send(mk(32'h200, 32'h0000_0000, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        drain();
        compared++;
        if ({decoded_cnt, illegal_cnt} !== {16'd1, 16'd1}) begin
            mismatched++;
            $display("FAIL illegal_count got=%0d/%0d want=1/1", decoded_cnt, illegal_cnt);
        end
        send(mk(32'h204, 32'h0000_0013, NOP, I_FORMAT, ARITHMETIC, ZERO, ZERO, ZERO, 32'h0, 1'b0));
        drain();
        compared++;
        if ({decoded_cnt, illegal_cnt} !== {16'd2, 16'd1}) begin
            mismatched++;
            $display("FAIL nop_count got=%0d/%0d want=2/1", decoded_cnt, illegal_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        fork
            begin
                send(mk(32'h300, 32'h1234_52B7, LUI, U_FORMAT, ARITHMETIC, T0, ZERO, ZERO, 32'h1234_5000, 1'b0));
                send(mk(32'h304, 32'h0020_A423, SW, S_FORMAT, STORE, ZERO, RA, SP, 32'h8, 1'b0));
                send(mk(32'h308, 32'h02C5_8533, MUL, R_FORMAT, ARITHMETIC, A0, A1, A2, 32'h0, 1'b0));
                send(mk(32'h30C, 32'hFF9F_F0EF, JAL, J_FORMAT, JUMP, RA, ZERO, ZERO, 32'hFFFF_FFF8, 1'b0));
            end
            begin
                int c;
                c = 0;
                @(negedge clk);
                while (!out_valid && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    compared++;
                    if ({out_valid, in_ready, out_pc, out_instr, out_imm} !==
                        {1'b1, 1'b0, 32'h300, 32'h1234_52B7, 32'h1234_5000}) begin
                        mismatched++;
                        $display("FAIL stall_hold cyc=%0d got=%b/%b/%h/%h/%h want=1/0/300/123452b7/12345000",
                                 k, out_valid, in_ready, out_pc, out_instr, out_imm);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({out_valid, decoded_cnt} !== {1'b0, 16'd6}) begin
            mismatched++;
            $display("FAIL bp_final got=%b/%0d want=0/6", out_valid, decoded_cnt);
        end
    endtask

    task automatic test_flush();
        logic [15:0] cnt_b;
        out_ready = 1'b0;
        send(mk(32'h400, 32'h3003_22F3, CSRRS, I_FORMAT, CSR, T0, T1, ZERO, 32'h300, 1'b0));
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h40B5_0533;
        in_pc = 32'h404;
        cnt_b = decoded_cnt;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        compared++;
        if ({out_valid, decoded_cnt} !== {1'b0, cnt_b}) begin
            mismatched++;
            $display("FAIL flush_hold got=%b/%0d want=0/%0d", out_valid, decoded_cnt, cnt_b);
        end
        sb.delete();
        send(mk(32'h408, 32'h0000_0073, ECALL, I_FORMAT, SYSTEM, ZERO, ZERO, ZERO, 32'h0, 1'b0));
        flush = 1'b1;
        out_ready = 1'b1;
        cnt_b = decoded_cnt;
        @(posedge clk);
        #1;
        flush = 1'b0;
        compared++;
        if ({out_valid, decoded_cnt} !== {1'b0, cnt_b + 16'd1}) begin
            mismatched++;
            $display("FAIL flush_drain got=%b/%0d want=0/%0d", out_valid, decoded_cnt, cnt_b + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(mk(32'h500, 32'h3003_22F3, CSRRS, I_FORMAT, CSR, T0, T1, ZERO, 32'h300, 1'b0));
        send(mk(32'h504, 32'h4030_D093, SRAI, I_FORMAT, SHIFT, RA, RA, ZERO, 32'h403, 1'b0));
        send(mk(32'h508, 32'h4230_D093, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        send(mk(32'h50C, 32'h40B5_0533, SUB, R_FORMAT, ARITHMETIC, A0, A0, A1, 32'h0, 1'b0));
        drain();
        compared++;
        if ({decoded_cnt, illegal_cnt} !== {16'd11, 16'd2}) begin
            mismatched++;
            $display("FAIL b2b_count got=%0d/%0d want=11/2", decoded_cnt, illegal_cnt);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(mk(32'h600, 32'h0000_0000, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        send(mk(32'h604, 32'hFFFF_FFFF, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        send(mk(32'h608, 32'h0050_0093, ADDI, I_FORMAT, ARITHMETIC, RA, ZERO, ZERO, 32'h5, 1'b0));
        send(mk(32'h60C, 32'h0000_0002, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        send(mk(32'h610, 32'h4230_D093, INVALID_INSTR, R_FORMAT, TRAP, ZERO, ZERO, ZERO, 32'h0, 1'b1));
        drain();
        compared++;
        if ({decoded_cnt, illegal_cnt} !== {16'd5, 16'd4}) begin
            mismatched++;
            $display("FAIL sat_wide got=%0d/%0d want=5/4", decoded_cnt, illegal_cnt);
        end
        compared++;
        if ({s_decoded_cnt, s_illegal_cnt} !== {2'd3, 2'd3}) begin
            mismatched++;
            $display("FAIL sat_narrow got=%0d/%0d want=3/3", s_decoded_cnt, s_illegal_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_reset_mid();
        test_illegal_nop();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
